// File: rtl/icon_update_ctrl.sv
// Frame-synchronous commit of rojobot location/info for the icon mapper, with stale detection.
// Define ICON_BLINK_EN to blink icon_en while stale; otherwise icon_en is tied high.
module icon_update_ctrl #(
  parameter int ROW_LAST     = 767,
  parameter int STALE_FRAMES = 60,
  parameter int BLINK_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_sysregs,
  input  logic [7:0]  locX_in,
  input  logic [7:0]  locY_in,
  input  logic [7:0]  botinfo_in,
  input  logic [11:0] pixel_row,
  output logic [7:0]  locXReg,
  output logic [7:0]  locYReg,
  output logic [7:0]  botInfoReg,
  output logic        upd_ack,
  output logic        frame_tick,
  output logic        stale,
  output logic [7:0]  overrun_cnt,
  output logic        icon_en
);

  // state   | meaning
  // IDLE    | nothing waiting to be shown
  // PENDING | shadow holds an update waiting for the frame boundary
  // COMMIT  | outputs just loaded; upd_ack high for this cycle
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  localparam int SW = $clog2(STALE_FRAMES + 1);

  state_t         state;
  logic           at_last;
  logic [7:0]     sh_x, sh_y, sh_info;
  logic           commit_go;
  logic [SW-1:0]  stale_cnt, stale_cnt_nxt;

  // at_last remembers that the previous row was the last visible one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_last    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      at_last    <= (pixel_row == 12'(ROW_LAST));
      frame_tick <= at_last && (pixel_row != 12'(ROW_LAST));
    end
  end

  assign commit_go = (state == PENDING) && frame_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_x        <= 8'h00;
      sh_y        <= 8'h00;
      sh_info     <= 8'h00;
      locXReg     <= 8'h00;
      locYReg     <= 8'h00;
      botInfoReg  <= 8'h00;
      upd_ack     <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      upd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_sysregs) begin
            sh_x    <= locX_in;
            sh_y    <= locY_in;
            sh_info <= botinfo_in;
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (frame_tick) begin
            // a same-cycle update is the freshest data, so it bypasses the shadow
            if (upd_sysregs) begin
              locXReg    <= locX_in;
              locYReg    <= locY_in;
              botInfoReg <= botinfo_in;
            end else begin
              locXReg    <= sh_x;
              locYReg    <= sh_y;
              botInfoReg <= sh_info;
            end
            upd_ack <= 1'b1;
            state   <= COMMIT;
          end else if (upd_sysregs) begin
            sh_x    <= locX_in;
            sh_y    <= locY_in;
            sh_info <= botinfo_in;
            if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
          end
        end
        COMMIT: begin
          if (upd_sysregs) begin
            sh_x    <= locX_in;
            sh_y    <= locY_in;
            sh_info <= botinfo_in;
            state   <= PENDING;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stale_cnt_nxt = stale_cnt;
    if (commit_go)
      stale_cnt_nxt = '0;
    else if (frame_tick && (stale_cnt != SW'(STALE_FRAMES)))
      stale_cnt_nxt = stale_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stale_cnt <= '0;
    else        stale_cnt <= stale_cnt_nxt;
  end

  assign stale = (stale_cnt == SW'(STALE_FRAMES));

`ifdef ICON_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt;
  logic          stale_nxt;

  assign stale_nxt = (stale_cnt_nxt == SW'(STALE_FRAMES));

  // icon_en snaps back to 1 on the same edge the stale counter clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      icon_en   <= 1'b1;
    end else if (!stale_nxt) begin
      blink_cnt <= '0;
      icon_en   <= 1'b1;
    end else if (stale && frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        icon_en   <= ~icon_en;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign icon_en = 1'b1;
`endif

endmodule

// File: tb/tb_icon_update_ctrl.sv
// Directed bench for icon_update_ctrl: vector table for the commit path, hand sequences for
// overrun saturation, stale/blink timing and reset while pending.
module tb_icon_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_sysregs;
  logic [7:0]  locX_in, locY_in, botinfo_in;
  logic [11:0] pixel_row;
  logic [7:0]  locXReg, locYReg, botInfoReg;
  logic        upd_ack, frame_tick, stale, icon_en;
  logic [7:0]  overrun_cnt;

  int total = 0;
  int bad = 0;
  int ack_hits = 0;
  int tick_hits = 0;

  icon_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .upd_sysregs(upd_sysregs),
    .locX_in(locX_in), .locY_in(locY_in), .botinfo_in(botinfo_in),
    .pixel_row(pixel_row),
    .locXReg(locXReg), .locYReg(locYReg), .botInfoReg(botInfoReg),
    .upd_ack(upd_ack), .frame_tick(frame_tick), .stale(stale),
    .overrun_cnt(overrun_cnt), .icon_en(icon_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [7:0]  x, y, info;
    logic [11:0] row;
    logic [7:0]  ex, ey, ei;
    logic        eack, etick;
    logic [7:0]  eovr;
  } vec_t;

  vec_t vecs[$];

`ifdef ICON_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (upd_ack) ack_hits++;
    if (frame_tick) tick_hits++;
  endtask

  task automatic frame();
    pixel_row = 12'd767;
    step();
    pixel_row = 12'd0;
    step();
    step();
  endtask

  task automatic add(input logic upd, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] info, input logic [11:0] row,
                     input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ei,
                     input logic eack, input logic etick, input logic [7:0] eovr);
    vec_t v;
    v.upd = upd; v.x = x; v.y = y; v.info = info; v.row = row;
    v.ex = ex; v.ey = ey; v.ei = ei; v.eack = eack; v.etick = etick; v.eovr = eovr;
    vecs.push_back(v);
  endtask

  initial begin
    int acks0, ticks0;
    rst_n = 1'b0; upd_sysregs = 1'b0;
    locX_in = 8'h00; locY_in = 8'h00; botinfo_in = 8'h00;
    pixel_row = 12'd100;

    //   upd x    y    info row   ex   ey   ei   ack tick ovr
    add(1, 8'h40, 8'h20, 8'h03, 100, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h40, 8'h20, 8'h03, 1, 0, 0);
    add(0, 8'h00, 8'h00, 8'h00,   1, 8'h40, 8'h20, 8'h03, 0, 0, 0);
    add(1, 8'h10, 8'h11, 8'h12,   1, 8'h40, 8'h20, 8'h03, 0, 0, 0);
    add(1, 8'h11, 8'h12, 8'h13,   1, 8'h40, 8'h20, 8'h03, 0, 0, 1);
    add(1, 8'h12, 8'h13, 8'h14,   1, 8'h40, 8'h20, 8'h03, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h40, 8'h20, 8'h03, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h40, 8'h20, 8'h03, 0, 1, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h12, 8'h13, 8'h14, 1, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   5, 8'h12, 8'h13, 8'h14, 0, 0, 2);
    add(1, 8'h10, 8'h11, 8'h12,   5, 8'h12, 8'h13, 8'h14, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h12, 8'h13, 8'h14, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h12, 8'h13, 8'h14, 0, 1, 2);
    add(1, 8'h22, 8'h23, 8'h24,   0, 8'h22, 8'h23, 8'h24, 1, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h22, 8'h23, 8'h24, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h22, 8'h23, 8'h24, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h22, 8'h23, 8'h24, 0, 1, 2);
    add(1, 8'h33, 8'h34, 8'h35,   0, 8'h22, 8'h23, 8'h24, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h22, 8'h23, 8'h24, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h22, 8'h23, 8'h24, 0, 1, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h33, 8'h34, 8'h35, 1, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h33, 8'h34, 8'h35, 0, 0, 2);
    add(1, 8'h50, 8'h51, 8'h52,   0, 8'h33, 8'h34, 8'h35, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h33, 8'h34, 8'h35, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h33, 8'h34, 8'h35, 0, 1, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h50, 8'h51, 8'h52, 1, 0, 2);
    add(1, 8'h51, 8'h52, 8'h53,   0, 8'h50, 8'h51, 8'h52, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h50, 8'h51, 8'h52, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h50, 8'h51, 8'h52, 0, 1, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h51, 8'h52, 8'h53, 1, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h51, 8'h52, 8'h53, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h51, 8'h52, 8'h53, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h51, 8'h52, 8'h53, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00, 767, 8'h51, 8'h52, 8'h53, 0, 0, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h51, 8'h52, 8'h53, 0, 1, 2);
    add(0, 8'h00, 8'h00, 8'h00,   0, 8'h51, 8'h52, 8'h53, 0, 0, 2);

    // reset state
    repeat (3) step();
    chk("rst_locX", 32'(locXReg), 32'h00);
    chk("rst_ack", 32'(upd_ack), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    chk("rst_ovr", 32'(overrun_cnt), 32'h0);
    chk("rst_icon", 32'(icon_en), 32'h1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      upd_sysregs = vecs[i].upd;
      locX_in = vecs[i].x; locY_in = vecs[i].y; botinfo_in = vecs[i].info;
      pixel_row = vecs[i].row;
      step();
      chk($sformatf("v%0d_locX", i), 32'(locXReg), 32'(vecs[i].ex));
      chk($sformatf("v%0d_locY", i), 32'(locYReg), 32'(vecs[i].ey));
      chk($sformatf("v%0d_info", i), 32'(botInfoReg), 32'(vecs[i].ei));
      chk($sformatf("v%0d_ack", i), 32'(upd_ack), 32'(vecs[i].eack));
      chk($sformatf("v%0d_tick", i), 32'(frame_tick), 32'(vecs[i].etick));
      chk($sformatf("v%0d_ovr", i), 32'(overrun_cnt), 32'(vecs[i].eovr));
    end

    // overrun saturation: one capture, then 300 overwrites starting from a count of 2
    upd_sysregs = 1'b1; locX_in = 8'h60; pixel_row = 12'd0;
    step();
    for (int i = 0; i < 300; i++) begin
      locX_in = 8'(8'h61 + i[7:0]);
      step();
      if (i == 251) chk("ovr_254", 32'(overrun_cnt), 32'd254);
    end
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    upd_sysregs = 1'b0;
    frame();
    chk("ovr_commit_ack", 32'(upd_ack), 32'h1);
    chk("ovr_commit_x", 32'(locXReg), 32'(8'(8'h61 + 8'd43)));
    step();

    // stale after 60 frames without a commit, then blink timing
    for (int f = 0; f < 59; f++) frame();
    chk("stale_59", 32'(stale), 32'h0);
    frame();
    chk("stale_60", 32'(stale), 32'h1);
    chk("icon_at_stale", 32'(icon_en), 32'h1);
    for (int f = 0; f < 14; f++) frame();
    chk("icon_f14", 32'(icon_en), 32'h1);
    frame();
    chk("icon_f15", 32'(icon_en), 32'(!BLINK));
    for (int f = 0; f < 15; f++) frame();
    chk("icon_f30", 32'(icon_en), 32'h1);
    for (int f = 0; f < 15; f++) frame();
    chk("icon_f45", 32'(icon_en), 32'(!BLINK));
    chk("stale_held", 32'(stale), 32'h1);
    upd_sysregs = 1'b1; locX_in = 8'h7A;
    step();
    upd_sysregs = 1'b0;
    frame();
    chk("stale_commit_ack", 32'(upd_ack), 32'h1);
    chk("stale_commit_clr", 32'(stale), 32'h0);
    chk("stale_commit_icon", 32'(icon_en), 32'h1);
    chk("stale_commit_x", 32'(locXReg), 32'h7A);
    step();

    // reset while pending, with the row-edge history armed beforehand
    upd_sysregs = 1'b1; locX_in = 8'h77;
    step();
    upd_sysregs = 1'b0; pixel_row = 12'd767;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locX", 32'(locXReg), 32'h00);
    chk("arst_ovr", 32'(overrun_cnt), 32'h00);
    pixel_row = 12'd0;
    step();
    rst_n = 1'b1;
    acks0 = ack_hits; ticks0 = tick_hits;
    repeat (3) step();
    chk("post_rst_no_tick", 32'(tick_hits - ticks0), 32'd0);
    frame();
    frame();
    chk("post_rst_ticks", 32'(tick_hits - ticks0), 32'd2);
    chk("post_rst_no_ack", 32'(ack_hits - acks0), 32'd0);
    chk("post_rst_locX", 32'(locXReg), 32'h00);
    chk("post_rst_ovr", 32'(overrun_cnt), 32'h00);
    chk("post_rst_stale", 32'(stale), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
